itch_frame_router: RTL and testbench

- Parametrised successor to the single-message header parser path.
- Consumes the raw TCP byte stream as SoupBinTCP-style frames: 2-byte big-endian length, then the ITCH message.
- Classifies each message by its type byte against a NUM_CH-entry type table and emits a start pulse plus a one-hot channel select, so multiple decoders (add/exec/cancel/...) share one byte bus.
- Drops unknown types and flags malformed lengths without losing frame sync.

---
 rtl/itch_frame_router.sv | 191 +++++++++++++++++++
 tb/tb_itch_frame_router.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/itch_frame_router.sv
// itch_frame_router
//   Splits a raw TCP byte stream into SoupBinTCP-style frames (2-byte
//   big-endian length, then one ITCH message). It classifies each message by
//   its type byte against a NUM_CH-entry code table. Accepted messages are
//   forwarded on a shared byte bus with a start pulse and a one-hot channel
//   select. Unknown types are dropped. Bad lengths are flagged. Frame sync is
//   kept in every case.
//
// Optional feature macro: ITCH_STATS_EN
//   When defined, adds saturating 32-bit message, drop and error counters.
//
// Handshake: tcp_byte_valid_in qualifies tcp_payload_in for one cycle. There
//   is no backpressure. payload_valid_out qualifies payload_out for one cycle,
//   and the sink must take every qualified byte.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   tcp_payload_in      stream byte
//   tcp_byte_valid_in   byte qualifier
//   payload_out         registered message byte (length bytes stripped)
//   payload_valid_out   payload_out qualifier (accepted messages only)
//   start_flag          pulse with the type byte on payload_out
//   ch_sel              one-hot channel, held from type byte to last byte
//   msg_type_out        type byte of the current/last accepted message
//   msg_end_out         pulse with the last message byte
//   drop_out            pulse when the type byte matches no channel
//   len_err_out         pulse when the length is 0 or above MAX_LEN
//   fsm_state           debug view of the parser state
//   msg_count_out, drop_count_out, err_count_out  (ITCH_STATS_EN only)
module itch_frame_router #(
    parameter int NUM_CH = 4,
    // Channel i uses bits [8i+7:8i]. The default is A,F,E,X with A on channel 0 (LSB).
    parameter logic [NUM_CH*8-1:0] TYPE_CODES = {8'h58, 8'h45, 8'h46, 8'h41},
    parameter int MAX_LEN = 64,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        tcp_payload_in,
    input  logic              tcp_byte_valid_in,
    output logic [7:0]        payload_out,
    output logic              payload_valid_out,
    output logic              start_flag,
    output logic [NUM_CH-1:0] ch_sel,
    output logic [7:0]        msg_type_out,
    output logic              msg_end_out,
    output logic              drop_out,
    output logic              len_err_out,
`ifdef ITCH_STATS_EN
    output logic [31:0]       msg_count_out,
    output logic [31:0]       drop_count_out,
    output logic [31:0]       err_count_out,
`endif
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_TYPE    = 3'd2,
        S_BODY    = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  remaining;
    logic [15:0]       len_raw;
    logic              hit;
    logic [NUM_CH-1:0] hit_onehot;
    logic              last_byte;

    assign fsm_state = state;
    assign len_raw   = {len_hi, tcp_payload_in};
    assign last_byte = (remaining == LEN_W'(1));

    // Scanning from index 0 upward makes the lowest-index match win when codes repeat.
    always_comb begin
        hit        = 1'b0;
        hit_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit && tcp_payload_in == TYPE_CODES[8*i +: 8]) begin
                hit           = 1'b1;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_LEN_HI;
            len_hi            <= '0;
            remaining         <= '0;
            payload_out       <= '0;
            payload_valid_out <= 1'b0;
            start_flag        <= 1'b0;
            ch_sel            <= '0;
            msg_type_out      <= '0;
            msg_end_out       <= 1'b0;
            drop_out          <= 1'b0;
            len_err_out       <= 1'b0;
        end else begin
            payload_valid_out <= 1'b0;
            start_flag        <= 1'b0;
            msg_end_out       <= 1'b0;
            drop_out          <= 1'b0;
            len_err_out       <= 1'b0;
            // The select lives through the last byte, then clears. A later
            // type byte in this block overrides the clear.
            if (msg_end_out) begin
                ch_sel <= '0;
            end
            if (tcp_byte_valid_in) begin
                case (state)
                    S_LEN_HI: begin
                        len_hi <= tcp_payload_in;
                        state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (len_raw == 16'd0) begin
                            len_err_out <= 1'b1;
                            state       <= S_LEN_HI;
                        end else if (32'(len_raw) > MAX_LEN) begin
                            // Oversized frames are still consumed so the next length lines up.
                            len_err_out <= 1'b1;
                            remaining   <= LEN_W'(len_raw);
                            state       <= S_DISCARD;
                        end else begin
                            remaining <= LEN_W'(len_raw);
                            state     <= S_TYPE;
                        end
                    end
                    S_TYPE: begin
                        remaining <= remaining - LEN_W'(1);
                        if (hit) begin
                            ch_sel            <= hit_onehot;
                            msg_type_out      <= tcp_payload_in;
                            start_flag        <= 1'b1;
                            payload_out       <= tcp_payload_in;
                            payload_valid_out <= 1'b1;
                            msg_end_out       <= last_byte;
                            state             <= last_byte ? S_LEN_HI : S_BODY;
                        end else begin
                            drop_out <= 1'b1;
                            ch_sel   <= '0;
                            state    <= last_byte ? S_LEN_HI : S_DISCARD;
                        end
                    end
                    S_BODY: begin
                        remaining         <= remaining - LEN_W'(1);
                        payload_out       <= tcp_payload_in;
                        payload_valid_out <= 1'b1;
                        if (last_byte) begin
                            msg_end_out <= 1'b1;
                            state       <= S_LEN_HI;
                        end
                    end
                    S_DISCARD: begin
                        remaining <= remaining - LEN_W'(1);
                        if (last_byte) begin
                            state <= S_LEN_HI;
                        end
                    end
                    default: state <= S_LEN_HI;
                endcase
            end
        end
    end

`ifdef ITCH_STATS_EN
    // The counters follow the registered pulses and stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_count_out  <= '0;
            drop_count_out <= '0;
            err_count_out  <= '0;
        end else begin
            if (msg_end_out && msg_count_out != 32'hFFFF_FFFF) begin
                msg_count_out <= msg_count_out + 32'd1;
            end
            if (drop_out && drop_count_out != 32'hFFFF_FFFF) begin
                drop_count_out <= drop_count_out + 32'd1;
            end
            if (len_err_out && err_count_out != 32'hFFFF_FFFF) begin
                err_count_out <= err_count_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_itch_frame_router.sv
// tb_itch_frame_router
//   Directed bench for itch_frame_router. Each table record is one clock:
//   the inputs driven before the edge and the registered outputs expected
//   just after it.
module tb_itch_frame_router;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tcp_payload_in;
    logic       tcp_byte_valid_in;
    logic [7:0] payload_out;
    logic       payload_valid_out;
    logic       start_flag;
    logic [3:0] ch_sel;
    logic [7:0] msg_type_out;
    logic       msg_end_out;
    logic       drop_out;
    logic       len_err_out;
    logic [2:0] fsm_state;
`ifdef ITCH_STATS_EN
    logic [31:0] msg_count_out;
    logic [31:0] drop_count_out;
    logic [31:0] err_count_out;
`endif

    always #5 clk = ~clk;

    itch_frame_router dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tcp_payload_in    (tcp_payload_in),
        .tcp_byte_valid_in (tcp_byte_valid_in),
        .payload_out       (payload_out),
        .payload_valid_out (payload_valid_out),
        .start_flag        (start_flag),
        .ch_sel            (ch_sel),
        .msg_type_out      (msg_type_out),
        .msg_end_out       (msg_end_out),
        .drop_out          (drop_out),
        .len_err_out       (len_err_out),
`ifdef ITCH_STATS_EN
        .msg_count_out     (msg_count_out),
        .drop_count_out    (drop_count_out),
        .err_count_out     (err_count_out),
`endif
        .fsm_state         (fsm_state)
    );

    typedef struct {
        logic       rst_n;
        logic       vld;
        logic [7:0] din;
        logic       pv;
        logic       sf;
        logic [3:0] ch;
        logic       me;
        logic       dr;
        logic       le;
        logic [7:0] mt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    // Payload is expected to equal the driven byte whenever pv is set.
    task automatic push(input logic r, input logic v, input logic [7:0] d,
                        input logic pv, input logic sf, input logic [3:0] ch,
                        input logic me, input logic dr, input logic le,
                        input logic [7:0] mt);
        vec_t t;
        t.rst_n = r; t.vld = v; t.din = d; t.pv = pv; t.sf = sf;
        t.ch = ch; t.me = me; t.dr = dr; t.le = le; t.mt = mt;
        vecs.push_back(t);
    endtask

    // A plain byte with no output event.
    task automatic quiet(input logic [7:0] d, input logic [3:0] ch, input logic [7:0] mt);
        push(1'b1, 1'b1, d, 1'b0, 1'b0, ch, 1'b0, 1'b0, 1'b0, mt);
    endtask

    task automatic idle(input int n, input logic [3:0] ch, input logic [7:0] mt);
        for (int k = 0; k < n; k++) push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, ch, 1'b0, 1'b0, 1'b0, mt);
    endtask

    task automatic check_vec(input int idx, input vec_t t);
        tests++;
        if (payload_valid_out !== t.pv || (t.pv && payload_out !== t.din) ||
            start_flag !== t.sf || ch_sel !== t.ch || msg_end_out !== t.me ||
            drop_out !== t.dr || len_err_out !== t.le || msg_type_out !== t.mt) begin
            fails++;
            $display("FAIL vec%0d: got pv=%b pay=%h sf=%b ch=%b me=%b dr=%b le=%b mt=%h, want pv=%b pay=%h sf=%b ch=%b me=%b dr=%b le=%b mt=%h",
                     idx, payload_valid_out, payload_out, start_flag, ch_sel, msg_end_out,
                     drop_out, len_err_out, msg_type_out, t.pv, t.din, t.sf, t.ch, t.me,
                     t.dr, t.le, t.mt);
        end
    endtask

    initial begin
        // ---- frame 1: 36-byte 'A' message, continuous valid
        quiet(8'h00, 4'b0000, 8'h00);
        quiet(8'h24, 4'b0000, 8'h00);
        push(1, 1, 8'h41, 1, 1, 4'b0001, 0, 0, 0, 8'h41);
        for (int k = 1; k <= 35; k++)
            push(1, 1, 8'(k), 1, 0, 4'b0001, (k == 35), 0, 0, 8'h41);
        // ---- frames 2/3: 'F' then 'X', back-to-back
        quiet(8'h00, 4'b0000, 8'h41);
        quiet(8'h03, 4'b0000, 8'h41);
        push(1, 1, 8'h46, 1, 1, 4'b0010, 0, 0, 0, 8'h46);
        push(1, 1, 8'hAA, 1, 0, 4'b0010, 0, 0, 0, 8'h46);
        push(1, 1, 8'hBB, 1, 0, 4'b0010, 1, 0, 0, 8'h46);
        quiet(8'h00, 4'b0000, 8'h46);
        quiet(8'h02, 4'b0000, 8'h46);
        push(1, 1, 8'h58, 1, 1, 4'b1000, 0, 0, 0, 8'h58);
        push(1, 1, 8'hCC, 1, 0, 4'b1000, 1, 0, 0, 8'h58);
        // ---- unknown type 'Z' dropped, then single-byte 'E'
        quiet(8'h00, 4'b0000, 8'h58);
        quiet(8'h04, 4'b0000, 8'h58);
        push(1, 1, 8'h5A, 0, 0, 4'b0000, 0, 1, 0, 8'h58);
        quiet(8'h01, 4'b0000, 8'h58);
        quiet(8'h02, 4'b0000, 8'h58);
        quiet(8'h03, 4'b0000, 8'h58);
        quiet(8'h00, 4'b0000, 8'h58);
        quiet(8'h01, 4'b0000, 8'h58);
        push(1, 1, 8'h45, 1, 1, 4'b0100, 1, 0, 0, 8'h45);
        // ---- zero length, oversized 80, then resync on 'A'
        quiet(8'h00, 4'b0000, 8'h45);
        push(1, 1, 8'h00, 0, 0, 4'b0000, 0, 0, 1, 8'h45);
        quiet(8'h00, 4'b0000, 8'h45);
        push(1, 1, 8'h50, 0, 0, 4'b0000, 0, 0, 1, 8'h45);
        for (int k = 0; k < 80; k++) quiet(8'h41, 4'b0000, 8'h45);
        quiet(8'h00, 4'b0000, 8'h45);
        quiet(8'h01, 4'b0000, 8'h45);
        push(1, 1, 8'h41, 1, 1, 4'b0001, 1, 0, 0, 8'h41);
        // ---- length boundary: 65 rejected, 64 accepted
        quiet(8'h00, 4'b0000, 8'h41);
        push(1, 1, 8'h41, 0, 0, 4'b0000, 0, 0, 1, 8'h41);
        for (int k = 0; k < 65; k++) quiet(8'h46, 4'b0000, 8'h41);
        quiet(8'h00, 4'b0000, 8'h41);
        quiet(8'h40, 4'b0000, 8'h41);
        push(1, 1, 8'h45, 1, 1, 4'b0100, 0, 0, 0, 8'h45);
        for (int k = 1; k <= 63; k++)
            push(1, 1, 8'(k + 100), 1, 0, 4'b0100, (k == 63), 0, 0, 8'h45);
        // ---- gapped input: 3 idle cycles between every byte
        quiet(8'h00, 4'b0000, 8'h45);
        idle(3, 4'b0000, 8'h45);
        quiet(8'h05, 4'b0000, 8'h45);
        idle(3, 4'b0000, 8'h45);
        push(1, 1, 8'h41, 1, 1, 4'b0001, 0, 0, 0, 8'h41);
        idle(3, 4'b0001, 8'h41);
        push(1, 1, 8'h11, 1, 0, 4'b0001, 0, 0, 0, 8'h41);
        idle(3, 4'b0001, 8'h41);
        push(1, 1, 8'h22, 1, 0, 4'b0001, 0, 0, 0, 8'h41);
        idle(3, 4'b0001, 8'h41);
        push(1, 1, 8'h33, 1, 0, 4'b0001, 0, 0, 0, 8'h41);
        idle(3, 4'b0001, 8'h41);
        push(1, 1, 8'h44, 1, 0, 4'b0001, 1, 0, 0, 8'h41);
        idle(1, 4'b0000, 8'h41);
        // ---- reset mid-message, then a fresh 'E' frame
        quiet(8'h00, 4'b0000, 8'h41);
        quiet(8'h10, 4'b0000, 8'h41);
        push(1, 1, 8'h41, 1, 1, 4'b0001, 0, 0, 0, 8'h41);
        push(1, 1, 8'h22, 1, 0, 4'b0001, 0, 0, 0, 8'h41);
        push(0, 1, 8'h33, 0, 0, 4'b0000, 0, 0, 0, 8'h00);
        push(0, 1, 8'h44, 0, 0, 4'b0000, 0, 0, 0, 8'h00);
        quiet(8'h00, 4'b0000, 8'h00);
        quiet(8'h02, 4'b0000, 8'h00);
        push(1, 1, 8'h45, 1, 1, 4'b0100, 0, 0, 0, 8'h45);
        push(1, 1, 8'h77, 1, 0, 4'b0100, 1, 0, 0, 8'h45);
        idle(2, 4'b0000, 8'h45);

        // ---- clock/reset
        rst_n = 1'b0;
        tcp_byte_valid_in = 1'b0;
        tcp_payload_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (payload_out !== 8'h00 || payload_valid_out !== 1'b0 || start_flag !== 1'b0 ||
            ch_sel !== 4'b0000 || msg_type_out !== 8'h00 || msg_end_out !== 1'b0 ||
            drop_out !== 1'b0 || len_err_out !== 1'b0 || fsm_state !== 3'd0) begin
            fails++;
            $display("FAIL reset: got pay=%h pv=%b sf=%b ch=%b mt=%h me=%b dr=%b le=%b st=%0d, want all zero",
                     payload_out, payload_valid_out, start_flag, ch_sel, msg_type_out,
                     msg_end_out, drop_out, len_err_out, fsm_state);
        end

        // ---- table replay
        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n             = vecs[i].rst_n;
            tcp_byte_valid_in = vecs[i].vld;
            tcp_payload_in    = vecs[i].din;
            @(posedge clk);
            #1;
            check_vec(i, vecs[i]);
        end

`ifdef ITCH_STATS_EN
        tests++;
        if (msg_count_out !== 32'd1 || err_count_out !== 32'd0 || drop_count_out !== 32'd0) begin
            fails++;
            $display("FAIL stats: got msg=%0d drop=%0d err=%0d, want msg=1 drop=0 err=0",
                     msg_count_out, drop_count_out, err_count_out);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
